// File: rtl/wb_burst_master_pkg.sv
// wb_burst_master shared types and codes.
// CTI/BTE encodings, FSM states, CTI selection helper.
package wb_burst_master_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP,
    FINISH
  } state_e;

  function automatic logic [2:0] cti_code(
    input logic burst,
    input logic last
  );
    if (!burst) return CTI_CLASSIC;
    return last ? CTI_END : CTI_INCR;
  endfunction

endpackage

// File: rtl/wb_master_fifo2.sv
// Two-entry FIFO with occupancy count.
// Push and pop may coincide, including when full.
module wb_master_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= push_data;
        wp      <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone block-transfer initiator.
// Moves cmd_len words between local streams and the bus.
module wb_burst_master
  import wb_burst_master_pkg::*;
#(
  parameter int    Dw         = 32,
  parameter int    Aw         = 10,
  parameter int    LENw       = 8,
  parameter int    SELw       = Dw / 8,
  parameter int    CTIw       = 3,
  parameter int    BTEw       = 2,
  parameter string BURST_MODE = "DISABLED",
  parameter int    MAX_RTY    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [Aw-1:0]   cmd_addr,
  input  logic [LENw-1:0] cmd_len,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [Dw-1:0]   wr_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [Dw-1:0]   rd_data,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [Dw-1:0]   m_dat_o,
  output logic [Aw-1:0]   m_addr_o,
  output logic [SELw-1:0] m_sel_o,
  output logic [CTIw-1:0] m_cti_o,
  output logic [BTEw-1:0] m_bte_o,
  output logic            m_stb_o,
  output logic            m_cyc_o,
  output logic            m_we_o,
  input  logic [Dw-1:0]   m_dat_i,
  input  logic            m_ack_i,
  input  logic            m_err_i,
  input  logic            m_rty_i
);

  localparam logic BURST = (BURST_MODE == "ENABLED");
  localparam int   RW    = $clog2(MAX_RTY + 2);

  state_e          state_q;
  state_e          state_d;
  logic            we_q;
  logic            we_d;
  logic [LENw-1:0] len_q;
  logic [LENw-1:0] len_d;
  logic [LENw-1:0] beat_q;
  logic [LENw-1:0] beat_d;
  logic [LENw-1:0] wacc_q;
  logic [RW-1:0]   rty_q;
  logic [Aw-1:0]   addr_q;
  logic            err_q;
  logic            cyc_q;
  logic            stb_q;
  logic            mwe_q;
  logic            done_q;
  logic [SELw-1:0] sel_q;
  logic [CTIw-1:0] cti_q;
  logic            cyc_d;
  logic            stb_d;
  logic [CTIw-1:0] cti_d;

  logic            cmd_hs;
  logic            wr_hs;
  logic            rd_hs;
  logic            term_err;
  logic            term_ack;
  logic            term_rty;
  logic            last_beat;
  logic            w_pop;
  logic            r_push;
  logic [1:0]      wcnt;
  logic [1:0]      rcnt;
  logic [1:0]      wcnt_d;
  logic [1:0]      rcnt_d;

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign wr_ready  = (state_q == XFER) && (wcnt != 2'd2) &&
                     (wacc_q < len_q);
  assign wr_hs     = wr_valid && wr_ready;
  assign rd_valid  = (rcnt != 2'd0);
  assign rd_hs     = rd_valid && rd_ready;

  // Terminations only count while a strobe is out.
  assign term_err  = stb_q && (m_err_i ||
                     (m_rty_i && (rty_q == RW'(MAX_RTY))));
  assign term_ack  = stb_q && m_ack_i && !term_err;
  assign term_rty  = stb_q && m_rty_i && !m_ack_i && !term_err;
  assign last_beat = (beat_q == len_q - LENw'(1));

  assign w_pop  = term_ack && we_q;
  assign r_push = term_ack && !we_q;

  assign wcnt_d = term_err ? 2'd0 :
                  wcnt + {1'b0, wr_hs} - {1'b0, w_pop};
  assign rcnt_d = rcnt + {1'b0, r_push} - {1'b0, rd_hs};

  wb_master_fifo2 #(.W(Dw)) u_wfifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (term_err),
    .push      (wr_hs),
    .push_data (wr_data),
    .pop       (w_pop),
    .head      (m_dat_o),
    .count     (wcnt)
  );

  wb_master_fifo2 #(.W(Dw)) u_rfifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (r_push),
    .push_data (m_dat_i),
    .pop       (rd_hs),
    .head      (rd_data),
    .count     (rcnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_hs)
          state_d = (cmd_len == '0) ? FINISH : XFER;
      end
      XFER: begin
        if (term_err)
          state_d = FINISH;
        else if (term_ack && last_beat)
          state_d = FINISH;
        else if (term_rty)
          state_d = GAP;
      end
      GAP:     state_d = XFER;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are registered from next-cycle values.
  always_comb begin
    len_d  = cmd_hs ? cmd_len : len_q;
    we_d   = cmd_hs ? cmd_we : we_q;
    beat_d = beat_q;
    if (cmd_hs)
      beat_d = '0;
    else if (term_ack)
      beat_d = beat_q + LENw'(1);
    cyc_d = (state_d == XFER) || (state_d == GAP);
    stb_d = 1'b0;
    if (state_d == XFER) begin
      if (we_d)
        stb_d = (wcnt_d != 2'd0);
      else
        stb_d = (rcnt_d != 2'd2) && (beat_d < len_d);
    end
    cti_d = CTIw'(CTI_CLASSIC);
    if (cyc_d)
      cti_d = CTIw'(cti_code(BURST,
                beat_d == len_d - LENw'(1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      len_q   <= '0;
      beat_q  <= '0;
      wacc_q  <= '0;
      rty_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      mwe_q   <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= '0;
      cti_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      if (cmd_hs)
        addr_q <= cmd_addr;
      else if (term_ack)
        addr_q <= addr_q + Aw'(1);
      if (cmd_hs)
        wacc_q <= '0;
      else if (wr_hs)
        wacc_q <= wacc_q + LENw'(1);
      if (cmd_hs || term_ack)
        rty_q <= '0;
      else if (term_rty)
        rty_q <= rty_q + RW'(1);
      if (cmd_hs)
        err_q <= 1'b0;
      else if (term_err)
        err_q <= 1'b1;
      cyc_q  <= cyc_d;
      stb_q  <= stb_d;
      mwe_q  <= cyc_d && we_d;
      done_q <= (state_d == FINISH);
      sel_q  <= {SELw{cyc_d}};
      cti_q  <= cti_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign m_addr_o = addr_q;
  assign m_sel_o  = sel_q;
  assign m_cti_o  = cti_q;
  assign m_bte_o  = BTEw'(BTE_LINEAR);
  assign m_stb_o  = stb_q;
  assign m_cyc_o  = cyc_q;
  assign m_we_o   = mwe_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master.
// Zero-wait responder with injectable rty/err terminations.
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [9:0]  cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic [31:0] rd_data;
  logic        busy, done, err;
  logic [31:0] m_dat_o;
  logic [9:0]  m_addr_o;
  logic [3:0]  m_sel_o;
  logic [2:0]  m_cti_o;
  logic [1:0]  m_bte_o;
  logic        m_stb_o, m_cyc_o, m_we_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i, m_err_i, m_rty_i;

  logic        c_cmd_ready, c_wr_ready, c_rd_valid;
  logic [31:0] c_rd_data, c_dat_o;
  logic        c_busy, c_done, c_err;
  logic [9:0]  c_addr_o;
  logic [3:0]  c_sel_o;
  logic [2:0]  c_cti_o;
  logic [1:0]  c_bte_o;
  logic        c_stb_o, c_cyc_o, c_we_o;

  int checks = 0;
  int failures = 0;

  int resp_beat = 0;
  int rty_given = 0;
  int rty_beat = -1;
  int rty_count = 0;
  int err_beat = -1;
  logic [31:0] wmem [0:1023];
  logic [31:0] rxq [$];
  logic bus_act, err_now, rty_now;

  always #5 clk = ~clk;

  wb_burst_master #(.BURST_MODE("ENABLED")) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err),
    .m_dat_o(m_dat_o), .m_addr_o(m_addr_o), .m_sel_o(m_sel_o),
    .m_cti_o(m_cti_o), .m_bte_o(m_bte_o),
    .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_we_o(m_we_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .m_err_i(m_err_i), .m_rty_i(m_rty_i)
  );

  // Classic-cycle twin sees identical inputs, so it tracks dut.
  wb_burst_master #(.BURST_MODE("DISABLED")) dut_cl (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(c_cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(c_wr_ready), .wr_data(wr_data),
    .rd_valid(c_rd_valid), .rd_ready(rd_ready), .rd_data(c_rd_data),
    .busy(c_busy), .done(c_done), .err(c_err),
    .m_dat_o(c_dat_o), .m_addr_o(c_addr_o), .m_sel_o(c_sel_o),
    .m_cti_o(c_cti_o), .m_bte_o(c_bte_o),
    .m_stb_o(c_stb_o), .m_cyc_o(c_cyc_o), .m_we_o(c_we_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .m_err_i(m_err_i), .m_rty_i(m_rty_i)
  );

  assign bus_act = m_cyc_o && m_stb_o && !reset;
  assign err_now = bus_act && (resp_beat == err_beat);
  assign rty_now = bus_act && !err_now && (resp_beat == rty_beat) &&
                   (rty_given < rty_count);
  assign m_ack_i = bus_act && !err_now && !rty_now;
  assign m_err_i = err_now;
  assign m_rty_i = rty_now;
  assign m_dat_i = 32'h90 + 32'(m_addr_o);

  always @(posedge clk) begin
    if (m_ack_i) begin
      resp_beat <= resp_beat + 1;
      rty_given <= 0;
      if (m_we_o) wmem[m_addr_o] <= m_dat_o;
    end else if (m_rty_i) begin
      rty_given <= rty_given + 1;
    end
  end

  always @(posedge clk)
    if (!reset && rd_valid && rd_ready) rxq.push_back(rd_data);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [9:0] a,
                       input logic [7:0] n);
    cmd_valid = 1'b1;
    cmd_we = we;
    cmd_addr = a;
    cmd_len = n;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (cmd_ready !== 1'b0) begin failures++;
      $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
    checks++;
    if ({m_cyc_o, m_stb_o, m_we_o, busy, done, err, wr_ready, rd_valid}
        !== 8'h00) begin failures++;
      $display("FAIL rst_ctrl got=%b exp=0",
        {m_cyc_o, m_stb_o, m_we_o, busy, done, err, wr_ready, rd_valid});
    end
    checks++;
    if ({m_cti_o, m_addr_o, m_dat_o} !== 45'd0) begin failures++;
      $display("FAIL rst_bus cti=%h addr=%h dat=%h exp=0",
        m_cti_o, m_addr_o, m_dat_o); end
    reset = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin failures++;
      $display("FAIL rst_ready_after got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_read_burst();
    int base;
    base = rxq.size();
    rd_ready = 1'b1;
    issue(1'b0, 10'h010, 8'd4);
    checks++;
    if ({m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_bte_o} !== 9'b110_1111_00)
    begin failures++;
      $display("FAIL rd_start cyc=%b stb=%b we=%b sel=%h bte=%h",
        m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_bte_o); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_addr_o !== 10'(10'h010 + i)) begin failures++;
        $display("FAIL rd_addr%0d got=%h exp=%h", i, m_addr_o,
          10'h010 + i); end
      checks++;
      if (m_cti_o !== ((i == 3) ? 3'b111 : 3'b010)) begin failures++;
        $display("FAIL rd_cti%0d got=%b", i, m_cti_o); end
      tick();
    end
    checks++;
    if ({done, m_cyc_o, m_stb_o} !== 3'b100) begin failures++;
      $display("FAIL rd_done got=%b exp=100", {done, m_cyc_o, m_stb_o});
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin failures++;
      $display("FAIL rd_idle got=%b exp=00", {done, busy}); end
    tick();
    checks++;
    if (rxq.size() - base !== 4) begin failures++;
      $display("FAIL rd_count got=%0d exp=4", rxq.size() - base); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rxq[base + i] !== 32'hA0 + i) begin failures++;
          $display("FAIL rd_data%0d got=%h exp=%h", i, rxq[base + i],
            32'hA0 + i); end
      end
    end
  endtask

  task automatic test_write_wrap();
    logic [31:0] d [3];
    d[0] = 32'h1111_0001;
    d[1] = 32'h2222_0002;
    d[2] = 32'h3333_0003;
    issue(1'b1, 10'h3FE, 8'd3);
    checks++;
    if ({m_cyc_o, m_stb_o, m_we_o, wr_ready} !== 4'b1011)
    begin failures++;
      $display("FAIL wr_start got=%b exp=1011",
        {m_cyc_o, m_stb_o, m_we_o, wr_ready}); end
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data = d[i];
      tick();
      wr_valid = 1'b0;
      checks++;
      if ({m_stb_o, m_addr_o} !== {1'b1, 10'(10'h3FE + i)})
      begin failures++;
        $display("FAIL wr_beat%0d stb=%b addr=%h exp_addr=%h", i,
          m_stb_o, m_addr_o, 10'(10'h3FE + i)); end
      checks++;
      if (m_dat_o !== d[i]) begin failures++;
        $display("FAIL wr_dat%0d got=%h exp=%h", i, m_dat_o, d[i]); end
      checks++;
      if (m_cti_o !== ((i == 2) ? 3'b111 : 3'b010)) begin failures++;
        $display("FAIL wr_cti%0d got=%b", i, m_cti_o); end
      checks++;
      if ({c_cti_o, c_stb_o, c_addr_o} !== {3'b000, 1'b1, m_addr_o})
      begin failures++;
        $display("FAIL wr_classic%0d cti=%b stb=%b addr=%h", i,
          c_cti_o, c_stb_o, c_addr_o); end
      tick();
      if (i < 2) begin
        checks++;
        if ({m_stb_o, m_cyc_o} !== 2'b01) begin failures++;
          $display("FAIL wr_empty%0d stb=%b cyc=%b exp stb=0 cyc=1", i,
            m_stb_o, m_cyc_o); end
      end
    end
    checks++;
    if ({done, m_cyc_o} !== 2'b10) begin failures++;
      $display("FAIL wr_done got=%b exp=10", {done, m_cyc_o}); end
    checks++;
    if ({wmem[10'h3FE], wmem[10'h3FF], wmem[10'h000]} !==
        {d[0], d[1], d[2]}) begin failures++;
      $display("FAIL wr_mem got=%h %h %h", wmem[10'h3FE],
        wmem[10'h3FF], wmem[10'h000]); end
    tick();
  endtask

  task automatic test_backpressure();
    int base, rb;
    base = rxq.size();
    rb = resp_beat;
    rd_ready = 1'b0;
    issue(1'b0, 10'h020, 8'd8);
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (resp_beat - rb !== 2) begin failures++;
      $display("FAIL bp_acks got=%0d exp=2", resp_beat - rb); end
    checks++;
    if ({m_stb_o, m_cyc_o, rd_valid} !== 3'b011) begin failures++;
      $display("FAIL bp_hold got=%b exp=011",
        {m_stb_o, m_cyc_o, rd_valid}); end
    checks++;
    if (rd_data !== 32'hB0) begin failures++;
      $display("FAIL bp_head got=%h exp=b0", rd_data); end
    rd_ready = 1'b1;
    for (int k = 0; k < 40 && done !== 1'b1; k++) tick();
    checks++;
    if (done !== 1'b1) begin failures++;
      $display("FAIL bp_timeout done=%b exp=1", done); end
    tick();
    tick();
    tick();
    checks++;
    if (rxq.size() - base !== 8) begin failures++;
      $display("FAIL bp_count got=%0d exp=8", rxq.size() - base); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rxq[base + i] !== 32'hB0 + i) begin failures++;
          $display("FAIL bp_data%0d got=%h exp=%h", i, rxq[base + i],
            32'hB0 + i); end
      end
    end
  endtask

  task automatic test_retry();
    int base;
    base = rxq.size();
    rty_beat = resp_beat + 1;
    rty_count = 2;
    issue(1'b0, 10'h040, 8'd3);
    tick();
    for (int r = 0; r < 2; r++) begin
      checks++;
      if ({m_stb_o, m_addr_o} !== {1'b1, 10'h041}) begin failures++;
        $display("FAIL rty_issue%0d stb=%b addr=%h exp addr=041", r,
          m_stb_o, m_addr_o); end
      tick();
      checks++;
      if ({m_stb_o, m_cyc_o} !== 2'b01) begin failures++;
        $display("FAIL rty_gap%0d stb=%b cyc=%b exp stb=0 cyc=1", r,
          m_stb_o, m_cyc_o); end
      tick();
    end
    checks++;
    if ({m_stb_o, m_addr_o} !== {1'b1, 10'h041}) begin failures++;
      $display("FAIL rty_reissue stb=%b addr=%h", m_stb_o, m_addr_o); end
    tick();
    checks++;
    if (m_addr_o !== 10'h042) begin failures++;
      $display("FAIL rty_next got=%h exp=042", m_addr_o); end
    tick();
    checks++;
    if ({done, err} !== 2'b10) begin failures++;
      $display("FAIL rty_done got=%b exp=10", {done, err}); end
    rty_beat = -1;
    tick();
    tick();
    checks++;
    if (rxq.size() - base !== 3 || rxq[base + 1] !== 32'hD1 ||
        rxq[base + 2] !== 32'hD2) begin failures++;
      $display("FAIL rty_data count=%0d exp=3 words d0..d2",
        rxq.size() - base); end
  endtask

  task automatic test_error();
    int base;
    err_beat = resp_beat + 1;
    wr_valid = 1'b1;
    wr_data = 32'hE000_0000;
    issue(1'b1, 10'h100, 8'd4);
    tick();
    wr_data = 32'hE000_0001;
    checks++;
    if ({m_stb_o, m_addr_o} !== {1'b1, 10'h100}) begin failures++;
      $display("FAIL err_b0 stb=%b addr=%h", m_stb_o, m_addr_o); end
    tick();
    wr_data = 32'hE000_0002;
    checks++;
    if ({m_stb_o, m_addr_o, m_dat_o} !== {1'b1, 10'h101, 32'hE000_0001})
    begin failures++;
      $display("FAIL err_b1 stb=%b addr=%h dat=%h", m_stb_o, m_addr_o,
        m_dat_o); end
    tick();
    err_beat = -1;
    wr_valid = 1'b0;
    checks++;
    if ({m_cyc_o, m_stb_o, done, err, wr_ready} !== 5'b00110)
    begin failures++;
      $display("FAIL err_end got=%b exp=00110",
        {m_cyc_o, m_stb_o, done, err, wr_ready}); end
    checks++;
    if (wmem[10'h100] !== 32'hE000_0000) begin failures++;
      $display("FAIL err_mem got=%h exp=e0000000", wmem[10'h100]); end
    tick();
    checks++;
    if ({done, err, busy} !== 3'b010) begin failures++;
      $display("FAIL err_sticky got=%b exp=010", {done, err, busy}); end
    base = rxq.size();
    issue(1'b0, 10'h050, 8'd1);
    checks++;
    if ({err, m_cti_o} !== {1'b0, 3'b111}) begin failures++;
      $display("FAIL err_clear err=%b cti=%b exp 0/111", err, m_cti_o);
    end
    for (int k = 0; k < 10 && done !== 1'b1; k++) tick();
    tick();
    tick();
    checks++;
    if (rxq.size() - base !== 1 || rxq[base] !== 32'hE0) begin
      failures++;
      $display("FAIL err_next_rd count=%0d exp=1 word e0",
        rxq.size() - base); end
  endtask

  task automatic test_reset_mid();
    int rb;
    logic saw_done;
    rd_ready = 1'b1;
    issue(1'b0, 10'h060, 8'd8);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({m_cyc_o, m_stb_o, done, busy, rd_valid} !== 5'b0) begin
      failures++;
      $display("FAIL rm_drop got=%b exp=00000",
        {m_cyc_o, m_stb_o, done, busy, rd_valid}); end
    reset = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      saw_done = saw_done | done | m_cyc_o;
    end
    checks++;
    if (saw_done !== 1'b0) begin failures++;
      $display("FAIL rm_nodone got=%b exp=0", saw_done); end
    rb = resp_beat;
    issue(1'b0, 10'h070, 8'd0);
    checks++;
    if ({done, busy, m_cyc_o, m_stb_o} !== 4'b1100) begin failures++;
      $display("FAIL len0_done got=%b exp=1100",
        {done, busy, m_cyc_o, m_stb_o}); end
    tick();
    checks++;
    if ({done, busy, cmd_ready} !== 3'b001) begin failures++;
      $display("FAIL len0_idle got=%b exp=001", {done, busy, cmd_ready});
    end
    checks++;
    if (resp_beat !== rb) begin failures++;
      $display("FAIL len0_bus got=%0d exp=%0d", resp_beat, rb); end
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_write_wrap();
    test_backpressure();
    test_retry();
    test_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
